// File: rtl/spi_responder.sv
// spi_responder: device end of a TM1638-style STB/CLK/DIO link (oversampled, LSB-first).
// Define SPI_RESPONDER_DIAG_EN to add the o_Diag_* observation ports.
module spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int READ_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_SPI_Stb,
  input  logic                          i_SPI_Clk,
  inout  wire                           io_SPI_Dio,
  input  logic [READ_WIDTH-1:0]         i_Keys,
  output logic                          o_Wr,
  output logic [ADDR_WIDTH-1:0]         o_Wr_Addr,
  output logic [7:0]                    o_Wr_Data,
  output logic [2:0]                    o_Brightness,
  output logic                          o_Display_On,
  output logic                          o_Busy
`ifdef SPI_RESPONDER_DIAG_EN
  ,
  output logic [2:0]                    o_Diag_State,
  output logic [$clog2(READ_WIDTH)-1:0] o_Diag_Bit_Cnt,
  output logic [7:0]                    o_Diag_Byte,
  output logic [7:0]                    o_Diag_Err_Cnt
`endif
);

  localparam int CW = $clog2(READ_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WDATA  = 3'd2,
    ST_RDATA  = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  // Input synchronisers and edge detection
  logic [SYNC_STAGES-1:0] stb_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dio_sync_q;
  logic                   stb_prev_q;
  logic                   clk_prev_q;
  logic                   stb_s;
  logic                   clk_s;
  logic                   dio_s;
  logic                   stb_fall;
  logic                   stb_rise;
  logic                   clk_rise;

  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign dio_s    = dio_sync_q[SYNC_STAGES-1];
  assign stb_fall = stb_prev_q & ~stb_s;
  assign stb_rise = ~stb_prev_q & stb_s;
  assign clk_rise = ~clk_prev_q & clk_s;

  // STB history resets low so a transaction already running at reset
  // release never looks like a fresh falling edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      stb_sync_q <= '0;
      clk_sync_q <= '1;
      dio_sync_q <= '0;
      stb_prev_q <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], i_SPI_Stb};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], i_SPI_Clk};
      dio_sync_q <= {dio_sync_q[SYNC_STAGES-2:0], io_SPI_Dio};
      stb_prev_q <= stb_s;
      clk_prev_q <= clk_s;
    end
  end

  // Protocol state
  state_t                  state_q,   state_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [6:0]              shift_q,   shift_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic                    fixed_q,   fixed_d;
  logic [READ_WIDTH-1:0]   keys_q,    keys_d;
  logic                    dio_oe_q,  dio_oe_d;
  logic                    wr_q,      wr_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]              wr_data_q, wr_data_d;
  logic [2:0]              bright_q,  bright_d;
  logic                    disp_on_q, disp_on_d;
  logic                    armed_q,   armed_d;
  logic [7:0]              rx_byte;
  logic                    byte_done;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      fixed_q   <= 1'b0;
      keys_q    <= '0;
      dio_oe_q  <= 1'b0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      bright_q  <= '0;
      disp_on_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      fixed_q   <= fixed_d;
      keys_q    <= keys_d;
      dio_oe_q  <= dio_oe_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      bright_q  <= bright_d;
      disp_on_q <= disp_on_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    fixed_d   = fixed_q;
    keys_d    = keys_q;
    dio_oe_d  = dio_oe_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bright_d  = bright_q;
    disp_on_d = disp_on_q;
    armed_d   = armed_q | stb_s;
    rx_byte   = {dio_s, shift_q};
    byte_done = 1'b0;

    if (stb_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      dio_oe_d  = 1'b0;
    end else if (stb_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = '0;
      shift_d   = '0;
      dio_oe_d  = 1'b0;
    end else if (clk_rise) begin
      unique case (state_q)
        ST_CMD, ST_WDATA, ST_IGNORE: begin
          shift_d = rx_byte[7:1];
          if (bit_cnt_q == CW'(7)) begin
            bit_cnt_d = '0;
            byte_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_RDATA: begin
          if (bit_cnt_q == CW'(READ_WIDTH - 1)) begin
            bit_cnt_d = '0;
            dio_oe_d  = 1'b0;
            state_d   = ST_IGNORE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (byte_done) begin
      unique case (state_q)
        ST_CMD: begin
          unique case (rx_byte[7:6])
            2'b01: begin
              if (rx_byte[1]) begin
                keys_d    = i_Keys;
                dio_oe_d  = 1'b1;
                bit_cnt_d = '0;
                state_d   = ST_RDATA;
              end else begin
                fixed_d = rx_byte[2];
                state_d = ST_IGNORE;
              end
            end
            2'b11: begin
              addr_d  = rx_byte[ADDR_WIDTH-1:0];
              state_d = ST_WDATA;
            end
            2'b10: begin
              bright_d  = rx_byte[2:0];
              disp_on_d = rx_byte[3];
              state_d   = ST_IGNORE;
            end
            default: state_d = ST_IGNORE;
          endcase
        end
        ST_WDATA: begin
          wr_d      = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_byte;
          if (!fixed_q) addr_d = addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // o_Wr is a single-cycle valid with no ready: the consumer must take it
  // that cycle; o_Wr_Addr/o_Wr_Data stay stable until the next write.
  assign o_Wr         = wr_q;
  assign o_Wr_Addr    = wr_addr_q;
  assign o_Wr_Data    = wr_data_q;
  assign o_Brightness = bright_q;
  assign o_Display_On = disp_on_q;
  assign o_Busy       = armed_q & ~stb_s;

  // Reset gates the driver combinationally so DIO floats in the reset cycle itself.
  assign io_SPI_Dio = (dio_oe_q && !i_Rst) ? keys_q[bit_cnt_q] : 1'bz;

`ifdef SPI_RESPONDER_DIAG_EN
  logic [7:0] diag_byte_q;
  logic [7:0] err_cnt_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      diag_byte_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (byte_done) diag_byte_q <= rx_byte;
      if (stb_rise && (bit_cnt_q != '0) && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign o_Diag_State   = state_q;
  assign o_Diag_Bit_Cnt = bit_cnt_q;
  assign o_Diag_Byte    = diag_byte_q;
  assign o_Diag_Err_Cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: bit-banged STB/CLK/DIO master, transaction-level model, write/read scoreboard.
module tb_spi_responder;
  localparam int SYNC_STAGES = 2;
  localparam int READ_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 4;
  localparam int RAM_DEPTH   = 1 << ADDR_WIDTH;

  // Clock / reset and DUT wiring
  logic                  clk = 1'b0;
  logic                  rst;
  logic                  stb;
  logic                  sclk;
  logic [READ_WIDTH-1:0] keys;
  logic                  m_oe;
  logic                  m_do;
  wire                   dio;
  logic                  o_wr;
  logic [ADDR_WIDTH-1:0] o_wr_addr;
  logic [7:0]            o_wr_data;
  logic [2:0]            o_bright;
  logic                  o_on;
  logic                  o_busy;
`ifdef SPI_RESPONDER_DIAG_EN
  logic [2:0]                    diag_state;
  logic [$clog2(READ_WIDTH)-1:0] diag_bit_cnt;
  logic [7:0]                    diag_byte;
  logic [7:0]                    diag_err_cnt;
`endif

  always #5 clk = ~clk;

  assign dio = m_oe ? m_do : 1'bz;
  pullup pu_dio (dio);

  spi_responder #(
    .SYNC_STAGES(SYNC_STAGES),
    .READ_WIDTH (READ_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_SPI_Stb   (stb),
    .i_SPI_Clk   (sclk),
    .io_SPI_Dio  (dio),
    .i_Keys      (keys),
    .o_Wr        (o_wr),
    .o_Wr_Addr   (o_wr_addr),
    .o_Wr_Data   (o_wr_data),
    .o_Brightness(o_bright),
    .o_Display_On(o_on),
    .o_Busy      (o_busy)
`ifdef SPI_RESPONDER_DIAG_EN
    ,
    .o_Diag_State  (diag_state),
    .o_Diag_Bit_Cnt(diag_bit_cnt),
    .o_Diag_Byte   (diag_byte),
    .o_Diag_Err_Cnt(diag_err_cnt)
`endif
  );

  // Scoreboard state
  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [ADDR_WIDTH+7:0] exp_q[$];
  logic [READ_WIDTH-1:0] rd_exp_q[$];
  logic [READ_WIDTH-1:0] rd_obs;
  event                  rd_done;
  logic [7:0]            ram_obs[RAM_DEPTH];
  logic [7:0]            ram_exp[RAM_DEPTH];

  // Reference model: TM1638 command meaning at transaction level
  int         m_addr;
  bit         m_fixed;
  int         m_bright;
  int         m_on;
  int         m_err;
  int         h;
  logic [7:0] tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_addr = 0; m_fixed = 0; m_bright = 0; m_on = 0; m_err = 0;
  endtask

  task automatic model_cmd(input logic [7:0] b);
    case (b[7:6])
      2'b01: if (!b[1]) m_fixed = b[2];
      2'b10: begin m_bright = int'(b[2:0]); m_on = int'(b[3]); end
      2'b11: m_addr = int'(b) % RAM_DEPTH;
      default: ;
    endcase
  endtask

  // Master driver
  task automatic stb_start();
    h = $urandom_range(SYNC_STAGES + 2, SYNC_STAGES + 4);
    stb = 1'b0;
    wait_clk(h);
    check("busy_active", o_busy, 1);
  endtask

  task automatic stb_end();
    wait_clk(h);
    stb  = 1'b1;
    m_oe = 1'b0;
    wait_clk(h + SYNC_STAGES + 4);
    check("busy_idle", o_busy, 0);
    check("dio_idle_hiz", dio, 1);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input bit release_last);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      m_do = b[i];
      m_oe = 1'b1;
      wait_clk(h);
      sclk = 1'b1;
      wait_clk(1);
      if (release_last && i == nbits - 1) m_oe = 1'b0;
      wait_clk(h - 1);
    end
  endtask

  task automatic read_bits(input int n, input int change_at, output logic [READ_WIDTH-1:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      wait_clk(h);
      w[i] = dio;
      if (i == change_at) keys = $urandom;
      sclk = 1'b1;
      wait_clk(h);
    end
  endtask

  task automatic run_txn();
    logic [7:0] c;
    stb_start();
    c = tx_q[0];
    model_cmd(c);
    send_bits(c, 8, 1'b0);
    for (int i = 1; i < tx_q.size(); i++) begin
      if (c[7:6] == 2'b11) begin
        exp_q.push_back({ADDR_WIDTH'(m_addr), tx_q[i]});
        ram_exp[m_addr] = tx_q[i];
        if (!m_fixed) m_addr = (m_addr + 1) % RAM_DEPTH;
      end
      send_bits(tx_q[i], 8, 1'b0);
    end
    stb_end();
    check("brightness", o_bright, m_bright);
    check("display_on", o_on, m_on);
  endtask

  task automatic txn_read(input logic [READ_WIDTH-1:0] k, input bit change);
    logic [READ_WIDTH-1:0] w;
    keys = k;
    stb_start();
    model_cmd(8'h42);
    send_bits(8'h42, 8, 1'b1);
    rd_exp_q.push_back(k);
    read_bits(READ_WIDTH, change ? 10 : -1, w);
    rd_obs = w;
    -> rd_done;
    stb_end();
  endtask

  // Monitors
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && o_wr) begin
        ram_obs[o_wr_addr] = o_wr_data;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL wr_unexpected: got write addr=0x%0h data=0x%0h, expected no write", o_wr_addr, o_wr_data);
        end else begin
          logic [ADDR_WIDTH+7:0] e;
          e = exp_q.pop_front();
          check("wr_addr", o_wr_addr, e[ADDR_WIDTH+7:8]);
          check("wr_data", o_wr_data, e[7:0]);
        end
      end
    end
  end

  initial begin
    forever begin
      @(rd_done);
      if (rd_exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL read_unexpected: got 0x%0h, expected no read", rd_obs);
      end else begin
        check("read_word", rd_obs, rd_exp_q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [READ_WIDTH-1:0] w;
    logic [31:0]           r;
    int                    kind;
    int                    n;

    rst = 1'b1; stb = 1'b1; sclk = 1'b1; m_oe = 1'b0; m_do = 1'b0; keys = '0; h = 4;
    for (int i = 0; i < RAM_DEPTH; i++) begin ram_obs[i] = '0; ram_exp[i] = '0; end
    model_reset();
    wait_clk(3);
    check("rst_wr", o_wr, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    check("rst_bright", o_bright, 0);
    check("rst_on", o_on, 0);
    check("rst_busy", o_busy, 0);
    check("rst_dio_hiz", dio, 1);
    rst = 1'b0;
    wait_clk(8);

    // Auto-increment, fixed-address and wrap-around writes
    tx_q = {8'h40};                          run_txn();
    tx_q = {8'hC0, 8'h11, 8'h22, 8'h33};     run_txn();
    tx_q = {8'h44};                          run_txn();
    tx_q = {8'hC5, 8'hAA, 8'hBB};            run_txn();
    tx_q = {8'h40};                          run_txn();
    tx_q = {8'hCF, 8'h01, 8'h02};            run_txn();

    // Display control
    tx_q = {8'h8B}; run_txn();
    tx_q = {8'h80}; run_txn();
    tx_q = {8'h8D}; run_txn();

    // Key read with i_Keys changing mid-read
    txn_read(32'h1234_5678, 1'b1);

    // Read aborted by STB: DIO must float once STB is seen high
    keys = '0;
    stb_start();
    send_bits(8'h42, 8, 1'b1);
    read_bits(12, -1, w);
    check("partial_read_bits", w, 0);
    check("partial_read_drive", dio, 0);
    stb = 1'b1;
    wait_clk(SYNC_STAGES + 3);
    check("partial_read_release", dio, 1);
    m_err++;
    wait_clk(h + 4);
`ifdef SPI_RESPONDER_DIAG_EN
    check("diag_err_after_read_abort", diag_err_cnt, m_err);
`endif

    // Data byte cut short after 5 bits: no write
    stb_start();
    model_cmd(8'hC3);
    send_bits(8'hC3, 8, 1'b0);
    send_bits(8'h5A, 5, 1'b0);
    stb_end();
    m_err++;
`ifdef SPI_RESPONDER_DIAG_EN
    check("diag_err_after_byte_abort", diag_err_cnt, m_err);
`endif

    // Reset in the middle of a read, then the rest of that transaction is dropped
    keys = '0;
    stb_start();
    send_bits(8'h42, 8, 1'b1);
    read_bits(10, -1, w);
    check("rst_rd_drive", dio, 0);
    rst = 1'b1;
    #1;
    check("rst_dio_same_cycle", dio, 1);
    wait_clk(1);
    model_reset();
    check("rst2_wr", o_wr, 0);
    check("rst2_wr_addr", o_wr_addr, 0);
    check("rst2_wr_data", o_wr_data, 0);
    check("rst2_bright", o_bright, m_bright);
    check("rst2_on", o_on, m_on);
    check("rst2_busy", o_busy, 0);
    wait_clk(1);
    rst = 1'b0;
    send_bits(8'hC0, 8, 1'b0);
    send_bits(8'h77, 8, 1'b0);
    stb_end();
`ifdef SPI_RESPONDER_DIAG_EN
    check("diag_err_after_reset", diag_err_cnt, m_err);
`endif

    // Randomised mix of transactions
    for (int it = 0; it < 24; it++) begin
      r    = $urandom;
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin tx_q = {{2'b01, r[5:3], r[2], 1'b0, r[0]}}; run_txn(); end
        1: begin
          tx_q = {{2'b11, r[5:0]}};
          n = $urandom_range(1, 6);
          for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
          run_txn();
        end
        2: begin
          tx_q = {{2'b10, r[5:0]}};
          if (r[8]) tx_q.push_back(8'($urandom));
          run_txn();
        end
        3: txn_read($urandom, r[9]);
        default: begin
          tx_q = {{2'b00, r[5:0]}};
          n = $urandom_range(0, 2);
          for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
          run_txn();
        end
      endcase
    end

    // Full-RAM load, display on at full brightness, key read
    tx_q = {8'h40}; run_txn();
    tx_q = {8'hC0};
    for (int j = 0; j < RAM_DEPTH; j++) tx_q.push_back(8'($urandom));
    run_txn();
    tx_q = {8'h8F}; run_txn();
    check("final_bright", o_bright, 7);
    check("final_on", o_on, 1);
    txn_read($urandom, 1'b0);

    wait_clk(10);
    for (int j = 0; j < RAM_DEPTH; j++) check("ram_image", ram_obs[j], ram_exp[j]);
    check("wr_queue_empty", exp_q.size(), 0);
    check("rd_queue_empty", rd_exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- Device-side (slave) end of the TM1638-style 3-wire SPI link: STB, CLK and a bidirectional DIO.
- Oversamples the link on the system clock, deserialises command and data bytes LSB-first, and decodes TM1638 data, address and display-control commands.
- Emits display-RAM write strobes, holds brightness/on state, and serialises a key-scan word back on DIO for read commands.
- Used as a loopback bench model for spi_fifo and as the device side on a second FPGA.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on STB/CLK/DIO inputs (>=2).
- READ_WIDTH, 32, width of key-scan word returned on read; multiple of 8.
- ADDR_WIDTH, 4, display RAM address width (16 bytes).

Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_SPI_Stb  input  1  strobe from master; low = transaction active.
- i_SPI_Clk  input  1  serial clock from master; idles high.
- io_SPI_Dio  inout  1  serial data; driven only during read phase, otherwise hi-Z.
- i_Keys  input  READ_WIDTH  key-scan word, captured at read-command decode.
- o_Wr  output  1  one-cycle strobe, display RAM write.
- o_Wr_Addr  output  ADDR_WIDTH  write address.
- o_Wr_Data  output  8  write data.
- o_Brightness  output  3  display brightness.
- o_Display_On  output  1  display enable.
- o_Busy  output  1  high while STB is low (synchronised).

Behaviour:
- Reset: o_Wr=0, o_Wr_Addr=0, o_Wr_Data=0, o_Brightness=0, o_Display_On=0, o_Busy=0, DIO hi-Z, state IDLE, bit/byte counters 0, auto-increment mode on.
- Input sync: each input passes SYNC_STAGES flops. Edge detection compares the last two synced samples.
- Supported master timing: CLK half-period >= SYNC_STAGES+2 system clocks. Shorter half-periods are unsupported.
- Sampling: DIO sampled at each synced CLK rising edge. LSB first, 8 bits per byte.
- STB falling: enter CMD, clear bit counter.
- STB rising: return to IDLE from any state, release DIO next cycle, discard any partial byte. No write is issued for a partial byte.
- States:
  - IDLE: waiting for STB falling.
  - CMD: first byte of a transaction.
  - WDATA: receiving display data.
  - RDATA: driving the key-scan word.
  - IGNORE: sink extra bytes.
- CMD decode, on the byte completing, by bits [7:6]:
  - 01 data command: bit1=1 -> capture i_Keys, go RDATA. Else bit2 sets fixed(1)/auto-increment(0) mode, go IGNORE.
  - 11 address command: addr <= byte[ADDR_WIDTH-1:0], go WDATA.
  - 10 display control: o_Brightness <= byte[2:0], o_Display_On <= byte[3] one cycle after byte completes, go IGNORE.
  - 00: go IGNORE.
- WDATA: each completed byte -> o_Wr=1 for one cycle with current addr/data; o_Wr_Data/o_Wr_Addr held until the next write. Address post-increments only in auto mode, wrapping 15->0.
- RDATA:
  - DIO driven from the cycle after decode with bit 0 of the captured word.
  - Bit index advances after each synced CLK rising edge.
  - After READ_WIDTH bits, DIO released and state -> IGNORE.
  - Master samples on its rising edge; the responder changes DIO at least SYNC_STAGES cycles later.
- Keys capture is atomic: i_Keys changes after capture do not affect the current read.
- Reset mid-transaction: immediate return to reset state, DIO hi-Z in the same cycle. A transaction in progress is dropped until the next STB falling edge.
- Mode persists across transactions. Brightness/on persist until the next display control.

Optional Feature:
- Macro: SPI_RESPONDER_DIAG_EN.
- Defined, adds outputs:
  - o_Diag_State [2:0]
  - o_Diag_Bit_Cnt [$clog2(READ_WIDTH)-1:0]
  - o_Diag_Byte [7:0]: last completed byte.
  - o_Diag_Err_Cnt [7:0]: counts STB rising with a nonzero partial bit count; saturates at 255; cleared by reset.
- Undefined: none of these ports or their logic exist; all other behaviour is identical.

Test Plan:
- Write, auto mode: STB low, bytes 0x40, STB high; STB low, 0xC0,0x11,0x22,0x33, STB high -> three o_Wr pulses, addr 0/1/2, data 0x11/0x22/0x33.
- Write, fixed mode: 0x44 transaction, then 0xC5,0xAA,0xBB -> two writes, both addr 5, data 0xAA then 0xBB. Auto wrap: 0x40 transaction, then 0xCF,0x01,0x02 -> addr 15 then 0.
- Display control: 0x8B -> o_Brightness=3, o_Display_On=1. Then 0x80 -> o_Display_On=0, o_Brightness=0.
- Read keys: i_Keys=0x12345678, transaction 0x42 then 32 clocks -> master samples 0x12345678 LSB-first. i_Keys changed mid-read has no effect. DIO hi-Z after STB high.
- Aborts: STB high after 5 bits of a data byte -> no o_Wr; with the macro defined, o_Diag_Err_Cnt increments by 1. i_Rst asserted mid-read -> DIO hi-Z the same cycle, all outputs at reset values.
- Loopback with spi_fifo (SPI_CYCLES=4): push 0x40, 0xC0 + 16 data bytes, 0x8F, 0x42 -> RAM image matches, brightness 7 / on 1, read word equals i_Keys.
